// File: rtl/pe_column_sequencer.sv
`timescale 1ns/1ps
// pe_column_sequencer
// Runs one dot-product job on a column of NUM_PE processing elements. For each
// job it reads vec_len input elements and weight words, clears the PE
// accumulators, feeds the element/weight pairs, waits out the 4-stage PE
// pipeline, and then captures all PE results into a holding register that is
// offered on a valid/ready output.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start, vec_len,            job request; the parameters are sampled with start
//   x_base, w_base
//   busy                       high whenever the sequencer is not idle
//   x_rd_en, x_addr, x_rdata   input-vector memory (1-cycle read latency)
//   w_rd_en, w_addr, w_rdata   weight memory (slice i feeds PE i)
//   pe_clr                     accumulator clear pulse (from a flop)
//   pe_data, pe_weight         PE operands, zero outside the feed phase
//   pe_result                  PE output registers
//   res_data, res_valid,       captured results with valid/ready handshake
//   res_ready
module pe_column_sequencer #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         vec_len,
  input  logic [ADDR_WIDTH-1:0]        x_base,
  input  logic [ADDR_WIDTH-1:0]        w_base,
  output logic                         busy,
  output logic                         x_rd_en,
  output logic [ADDR_WIDTH-1:0]        x_addr,
  input  logic [DATA_WIDTH-1:0]        x_rdata,
  output logic                         w_rd_en,
  output logic [ADDR_WIDTH-1:0]        w_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0] w_rdata,
  output logic                         pe_clr,
  output logic [DATA_WIDTH-1:0]        pe_data,
  output logic [NUM_PE*DATA_WIDTH-1:0] pe_weight,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_result,
  output logic [NUM_PE*DATA_WIDTH-1:0] res_data,
  output logic                         res_valid,
  input  logic                         res_ready
);

  localparam int unsigned BUS_W        = NUM_PE * DATA_WIDTH;
  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned DCNT_W       = $clog2(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  k_q, k_d;
  logic [DCNT_W-1:0]     d_q, d_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] xb_q, xb_d;
  logic [ADDR_WIDTH-1:0] wb_q, wb_d;

  logic                  busy_d, x_rd_en_d, w_rd_en_d, pe_clr_d, res_valid_d;
  logic [ADDR_WIDTH-1:0] x_addr_d, w_addr_d;
  logic [BUS_W-1:0]      res_data_d;

  // The memory data already arrives one cycle after the read, so the operands
  // are only gated (not re-registered) to keep element j in cycle C(j+1).
  assign pe_data   = (state_q == S_FEED) ? x_rdata : '0;
  assign pe_weight = (state_q == S_FEED) ? w_rdata : '0;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      d_q       <= '0;
      len_q     <= '0;
      xb_q      <= '0;
      wb_q      <= '0;
      busy      <= 1'b0;
      x_rd_en   <= 1'b0;
      w_rd_en   <= 1'b0;
      x_addr    <= '0;
      w_addr    <= '0;
      pe_clr    <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      d_q       <= d_d;
      len_q     <= len_d;
      xb_q      <= xb_d;
      wb_q      <= wb_d;
      busy      <= busy_d;
      x_rd_en   <= x_rd_en_d;
      w_rd_en   <= w_rd_en_d;
      x_addr    <= x_addr_d;
      w_addr    <= w_addr_d;
      pe_clr    <= pe_clr_d;
      res_data  <= res_data_d;
      res_valid <= res_valid_d;
    end
  end

  // Next state plus the next value of every registered output.
  // Reads are scheduled one cycle ahead so they appear in C0..C(n-1).
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    d_d        = d_q;
    len_d      = len_q;
    xb_d       = xb_q;
    wb_d       = wb_q;
    x_rd_en_d  = 1'b0;
    w_rd_en_d  = 1'b0;
    x_addr_d   = x_addr;
    w_addr_d   = w_addr;
    res_data_d = res_data;

    case (state_q)
      S_IDLE: begin
        if (start && (vec_len != '0)) begin
          state_d   = S_CLEAR;
          len_d     = vec_len;
          xb_d      = x_base;
          wb_d      = w_base;
          x_rd_en_d = 1'b1;
          w_rd_en_d = 1'b1;
          x_addr_d  = x_base;
          w_addr_d  = w_base;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        k_d     = LEN_WIDTH'(1);
        if (k_d < len_q) begin
          x_rd_en_d = 1'b1;
          w_rd_en_d = 1'b1;
          x_addr_d  = xb_q + ADDR_WIDTH'(k_d);
          w_addr_d  = wb_q + ADDR_WIDTH'(k_d);
        end
      end
      S_FEED: begin
        if (k_q == len_q) begin
          state_d = S_DRAIN;
          d_d     = '0;
        end else begin
          k_d = k_q + LEN_WIDTH'(1);
          if (k_d < len_q) begin
            x_rd_en_d = 1'b1;
            w_rd_en_d = 1'b1;
            x_addr_d  = xb_q + ADDR_WIDTH'(k_d);
            w_addr_d  = wb_q + ADDR_WIDTH'(k_d);
          end
        end
      end
      S_DRAIN: begin
        if (d_q == DCNT_W'(DRAIN_CYCLES - 1)) begin
          res_data_d = pe_result;
          state_d    = S_OUT;
        end else begin
          d_d = d_q + DCNT_W'(1);
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    pe_clr_d    = (state_d == S_CLEAR);
    res_valid_d = (state_d == S_OUT);
  end

endmodule

// File: tb/tb_pe_column_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for pe_column_sequencer with behavioural memories and a
// 4-stage Q5.6 PE column model.
module tb_pe_column_sequencer;

  localparam int unsigned DW = 12;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned BW = NP * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] vec_len;
  logic [AW-1:0] x_base, w_base;
  logic          busy;
  logic          x_rd_en, w_rd_en;
  logic [AW-1:0] x_addr, w_addr;
  logic [DW-1:0] x_rdata = 12'h5A5;
  logic [BW-1:0] w_rdata = {4{12'h3C3}};
  logic          pe_clr;
  logic [DW-1:0] pe_data;
  logic [BW-1:0] pe_weight, pe_result, res_data;
  logic          res_valid, res_ready;

  pe_column_sequencer #(
    .DATA_WIDTH(DW), .NUM_PE(NP), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .x_base(x_base), .w_base(w_base), .busy(busy),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_rdata(x_rdata),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .pe_clr(pe_clr), .pe_data(pe_data), .pe_weight(pe_weight),
    .pe_result(pe_result), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous memories
  logic [DW-1:0] x_mem [256];
  logic [BW-1:0] w_mem [256];
  always @(posedge clk) begin
    if (x_rd_en) x_rdata <= x_mem[x_addr];
    if (w_rd_en) w_rdata <= w_mem[w_addr];
  end

  task automatic putx(input int a, input logic [DW-1:0] x);
    x_mem[a] = x;
  endtask
  task automatic putw(input int a, input logic [DW-1:0] w0, w1, w2, w3);
    w_mem[a] = {w3, w2, w1, w0};
  endtask
  function automatic logic [BW-1:0] pack(input logic [DW-1:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  // PE column model: multiply, two delay stages, accumulate (result in Cn+4)
  function automatic logic signed [DW-1:0] pe_mul(input logic signed [DW-1:0] a, b);
    logic signed [2*DW-1:0] p;
    p = a * b;
    return DW'(p >>> 6);
  endfunction

  logic signed [DW-1:0] s1 [NP];
  logic signed [DW-1:0] s2 [NP];
  logic signed [DW-1:0] s3 [NP];
  logic signed [DW-1:0] acc [NP];
  wire pe_rst = rst | pe_clr;

  always @(posedge clk or posedge pe_rst) begin
    if (pe_rst) begin
      for (int i = 0; i < NP; i++) begin
        s1[i] <= '0; s2[i] <= '0; s3[i] <= '0; acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        s1[i]  <= pe_mul(pe_data, pe_weight[i*DW +: DW]);
        s2[i]  <= s1[i];
        s3[i]  <= s2[i];
        acc[i] <= acc[i] + s3[i];
      end
    end
  end

  always_comb begin
    pe_result = '0;
    for (int i = 0; i < NP; i++) pe_result[i*DW +: DW] = acc[i];
  end

  // Scoreboard
  typedef struct {
    logic [BW-1:0] data;
    int            lat;
  } exp_t;
  exp_t sb[$];

  int            job_s = 0;
  int            job_n = 0;
  logic [AW-1:0] job_xb = '0;
  logic [AW-1:0] job_wb = '0;
  bit            job_active = 1'b0;
  bit            rv_seen = 1'b0;
  int            rd_x = 0;
  int            rd_w = 0;

  // Monitor: read addresses, operand gating, result latency and data
  always @(negedge clk) begin
    if (!rst) begin
      if (job_active) begin
        if (x_rd_en) begin chk("x_addr", 64'(x_addr), 64'(AW'(job_xb + AW'(rd_x)))); rd_x++; end
        if (w_rd_en) begin chk("w_addr", 64'(w_addr), 64'(AW'(job_wb + AW'(rd_w)))); rd_w++; end
      end else if (x_rd_en || w_rd_en) begin
        chk("idle_read", 64'({x_rd_en, w_rd_en}), 64'd0);
      end

      if (job_active && (cyc > job_s) && (cyc <= job_s + job_n)) begin
        chk("feed_data", 64'(pe_data), 64'(x_mem[AW'(job_xb + AW'(cyc - job_s - 1))]));
        chk("feed_weight", 64'(pe_weight), 64'(w_mem[AW'(job_wb + AW'(cyc - job_s - 1))]));
      end else begin
        chk("zero_gate", 64'({pe_data, pe_weight}), 64'd0);
      end

      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(res_valid), 64'd0);
        end else begin
          if (!rv_seen) begin
            chk("latency", 64'(cyc - job_s), 64'(sb[0].lat));
            rv_seen = 1'b1;
          end
          if (res_ready) begin
            chk("res_data", 64'(res_data), 64'(sb[0].data));
            void'(sb.pop_front());
            rv_seen    = 1'b0;
            job_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int n, input logic [AW-1:0] xb, wb,
                       input bit expect_res, input logic [BW-1:0] exp);
    @(negedge clk);
    start = 1'b1; vec_len = LW'(n); x_base = xb; w_base = wb;
    @(posedge clk);
    #1;
    start  = 1'b0;
    job_s  = cyc;
    job_n  = n;
    job_xb = xb;
    job_wb = wb;
    rd_x   = 0;
    rd_w   = 0;
    rv_seen = 1'b0;
    job_active = 1'b1;
    if (expect_res) sb.push_back('{data: exp, lat: n + 5});
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (job_active && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (job_active) begin
      chk("job_timeout", 64'(job_active), 64'd0);
      job_active = 1'b0;
      sb.delete();
    end else begin
      chk("x_read_count", 64'(rd_x), 64'(n));
      chk("w_read_count", 64'(rd_w), 64'(n));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({busy, x_rd_en, w_rd_en, pe_clr, res_valid}), 64'd0);
    chk({tag, "_addr"}, 64'({x_addr, w_addr}), 64'd0);
    chk({tag, "_pe"}, 64'({pe_data, pe_weight}), 64'd0);
    chk({tag, "_res"}, 64'(res_data), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] exp_a;
    int t;
    rst = 1'b1; start = 1'b0; vec_len = '0; x_base = '0; w_base = '0; res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = 12'h0A3;
      w_mem[i] = {4{12'h071}};
    end
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic dot product: 1.0*1 + 2.0*1 + 0.5*1 etc.
    putx(10, 12'd64); putx(11, 12'd128); putx(12, 12'd32);
    for (int i = 20; i < 23; i++) putw(i, 12'd64, 12'd32, 12'hFC0, 12'd0);
    issue(3, 8'd10, 8'd20, 1'b1, pack(12'd224, 12'd112, 12'hF20, 12'd0));
    wait_done(3);

    // Reset in the middle of FEED
    issue(10, 8'd100, 8'd100, 1'b0, '0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    job_active = 1'b0;
    #1;
    chk_reset_outputs("midjob_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("post_reset_idle", 64'({busy, res_valid}), 64'd0);
    end

    // vec_len = 1
    putx(5, 12'd128);
    putw(6, 12'd96, 12'hFE0, 12'd64, 12'd0);
    issue(1, 8'd5, 8'd6, 1'b1, pack(12'd192, 12'hFC0, 12'd128, 12'd0));
    wait_done(1);

    // Address wrap: 254, 255, 0, 1
    putx(254, 12'd64); putx(255, 12'd128); putx(0, 12'd192); putx(1, 12'hFC0);
    putw(253, 12'd64, 12'd32, 12'd0, 12'd0); putw(254, 12'd64, 12'd32, 12'd0, 12'd0);
    putw(255, 12'd64, 12'd32, 12'd0, 12'd0); putw(0, 12'd64, 12'd32, 12'd0, 12'd0);
    issue(4, 8'd254, 8'd253, 1'b1, pack(12'd320, 12'd160, 12'd0, 12'd0));
    wait_done(4);

    // vec_len = 0 is ignored
    @(negedge clk);
    start = 1'b1; vec_len = '0; x_base = 8'd3; w_base = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("len0_busy", 64'(busy), 64'd0);
    end

    // Stalled output with ignored starts, then a back-to-back job
    putx(30, 12'd64); putx(31, 12'd64);
    putw(40, 12'd64, 12'd128, 12'd0, 12'd0); putw(41, 12'd64, 12'd128, 12'd0, 12'd0);
    exp_a = pack(12'd128, 12'd256, 12'd0, 12'd0);
    res_ready = 1'b0;
    issue(2, 8'd30, 8'd40, 1'b1, exp_a);
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", 64'(res_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 1 || i == 3); vec_len = 8'd3; x_base = '0; w_base = '0;
      chk("stall_data", 64'(res_data), 64'(exp_a));
      chk("stall_busy", 64'({busy, res_valid}), 64'd3);
    end
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b1;
    wait_done(2);

    putx(50, 12'd32); putx(51, 12'd32);
    putw(60, 12'd64, 12'hFC0, 12'd0, 12'd0); putw(61, 12'd64, 12'hFC0, 12'd0, 12'd0);
    issue(2, 8'd50, 8'd60, 1'b1, pack(12'd64, 12'hFC0, 12'd0, 12'd0));
    wait_done(2);

    // vec_len = 255
    for (int i = 0; i < 255; i++) begin
      putx(i, 12'd64);
      putw(i + 1, 12'd1, 12'd2, 12'd0, 12'hFFF);
    end
    issue(255, 8'd0, 8'd1, 1'b1, pack(12'd255, 12'd510, 12'd0, 12'hF01));
    wait_done(255);

    repeat (3) @(negedge clk);
    chk("final_idle", 64'({busy, res_valid}), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_column_sequencer.md
# pe_column_sequencer

Sequencer for a column of NUM_PE fixed-point processing elements that share one broadcast data stream, each with its own weight stream. On each job it:
- reads input-vector elements and weight words from synchronous memories;
- clears the PE accumulators and feeds exactly vec_len element/weight pairs;
- waits out the fixed 4-stage PE pipeline;
- captures all PE results into a holding register offered on a valid/ready output.

It sits between the vector/weight buffers and the PE column in the LSTM gate datapath.

## Interface
Parameters:
- DATA_WIDTH, 12, word width (Q5.6 signed fixed point).
- NUM_PE, 4, number of PEs in the column.
- ADDR_WIDTH, 8, memory address width.
- LEN_WIDTH, 8, width of vec_len.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job request; honoured only in IDLE with vec_len != 0.
- vec_len  in  LEN_WIDTH  dot-product length; sampled with start.
- x_base  in  ADDR_WIDTH  first input-vector address; sampled with start.
- w_base  in  ADDR_WIDTH  first weight address; sampled with start.
- busy  out  1  high whenever state != IDLE.
- x_rd_en  out  1  input memory read enable.
- x_addr  out  ADDR_WIDTH  input memory address.
- x_rdata  in  DATA_WIDTH  input memory data, valid the cycle after x_rd_en.
- w_rd_en  out  1  weight memory read enable.
- w_addr  out  ADDR_WIDTH  weight memory address.
- w_rdata  in  NUM_PE*DATA_WIDTH  weight word (PE i at slice i), valid the cycle after w_rd_en.
- pe_clr  out  1  registered accumulator clear pulse to the PE column.
- pe_data  out  DATA_WIDTH  broadcast data to all PEs.
- pe_weight  out  NUM_PE*DATA_WIDTH  per-PE weights.
- pe_result  in  NUM_PE*DATA_WIDTH  PE output registers.
- res_data  out  NUM_PE*DATA_WIDTH  captured results.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.

## Operation
States: IDLE, CLEAR, FEED, DRAIN, OUT.
- **IDLE:**
  - start && vec_len != 0 → latch vec_len, x_base and w_base, then go to CLEAR.
  - start with vec_len == 0 is ignored.
- **CLEAR (1 cycle):**
  - pe_clr = 1.
  - Issue reads for element 0: x_rd_en = w_rd_en = 1, x_addr = x_base, w_addr = w_base.
  - Go to FEED with element counter k = 1.
- **FEED (vec_len cycles):**
  - pe_data / pe_weight = x_rdata / w_rdata, the data returned for the previous cycle's read.
  - While k < vec_len: issue read k at x_base+k and w_base+k, then increment k.
  - On the last FEED cycle no read is issued; go to DRAIN with drain counter 0.
- **DRAIN (4 cycles):**
  - pe_data = pe_weight = 0.
  - On the 4th cycle: res_data <= pe_result and go to OUT.
- **OUT:**
  - res_valid = 1; res_data is held stable.
  - res_valid && res_ready → IDLE. Acceptance is allowed in the first OUT cycle.
- **Zero gating:** outside FEED, pe_data and pe_weight are forced to 0, so the free-running PE accumulators see zero products.
- **Address arithmetic:** modulo 2^ADDR_WIDTH; base+k wraps silently.
- **No result arithmetic:** results are passed through unchanged. Overflow and saturation are the PE's concern.
- **start while busy:** ignored. Inputs are not re-sampled mid-job.
- **rst mid-job:** immediate return to IDLE; the job is abandoned with no result.

## Timing
- **Reset values:** busy=0, x_rd_en=0, w_rd_en=0, x_addr=0, w_addr=0, pe_clr=0, pe_data=0, pe_weight=0, res_data=0, res_valid=0; state IDLE.
- **Cycle numbering:** start sampled at edge S; CLEAR is cycle C0 = S+1; FEED covers C1..Cn, where n = vec_len.
- **Element timing:** element j appears on pe_data/pe_weight in cycle C(j+1).
- **pe_clr:** high exactly during C0, driven from a flop. The PE column ORs it into its async reset, so accumulators are zero entering C1.
- **PE pipeline:** the last element (cycle Cn) reaches the PE output register in cycle Cn+4.
- **Capture:** DRAIN covers Cn+1..Cn+4; capture happens at the end of Cn+4.
- **Result latency:** res_valid first high at S+n+6 (n=1 → S+7). Earliest next start is sampled the cycle after acceptance.
- **busy:** high from S+1 through the acceptance cycle, inclusive.
- **Memory reads:** exactly n reads per memory per job, in cycles C0..C(n-1).

## Test plan
- **Reset:** assert rst mid-FEED → all outputs return to their reset values asynchronously; state returns to IDLE; no res_valid afterwards.
- **Basic dot product:**
  - Stimulus: vec_len=3, x = {64,128,32} (1.0, 2.0, 0.5); PE0 weights = {64,64,64}; PE1 weights = {32,32,32}.
  - Required: res_data PE0 = 224 (3.5), PE1 = 112 (1.75); res_valid at S+9.
  - Reads must hit x_base+0..2 only.
- **Back-to-back jobs with stall:** hold res_ready=0 for 5 cycles → res_data stable and busy=1; start pulses during this time are ignored; the second job's result is unaffected by the first (clear verified).
- **vec_len boundaries:**
  - vec_len=0 → no activity, busy stays 0.
  - vec_len=1 → res_valid at S+7.
  - vec_len=255 → exactly 255 reads per memory.
- **Address wrap:** x_base=254, vec_len=4 → x_addr sequence 254, 255, 0, 1.
- **Zero gating:** during IDLE/DRAIN/OUT, pe_data and pe_weight are 0 even when x_rdata/w_rdata are nonzero.
